// File: rtl/sdram_port_arb_if.sv
// Bundle of requester-side and sdram_raw-side signals for the port arbiter.
interface sdram_port_arb_if #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned ADDR_W = 25
);
    logic [NPORTS-1:0]        req_enable;
    logic [NPORTS*ADDR_W-1:0] req_addr;
    logic [NPORTS-1:0]        req_write;
    logic [NPORTS*32-1:0]     req_wdata;
    logic [NPORTS*2-1:0]      req_width;
    logic [31:0]              req_rdata;
    logic [NPORTS-1:0]        req_ready;
    logic [NPORTS-1:0]        req_err;

    logic                     mem_enable;
    logic [ADDR_W-2:0]        mem_addr;
    logic                     mem_write;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_dqm_mask;
    logic [31:0]              mem_rdata;
    logic                     mem_ready;

    // Requesters plus the memory model drive this side.
    modport master (
        output req_enable, req_addr, req_write, req_wdata, req_width,
        input  req_rdata, req_ready, req_err,
        input  mem_enable, mem_addr, mem_write, mem_wdata, mem_dqm_mask,
        output mem_rdata, mem_ready
    );

    // The arbiter itself.
    modport slave (
        input  req_enable, req_addr, req_write, req_wdata, req_width,
        output req_rdata, req_ready, req_err,
        output mem_enable, mem_addr, mem_write, mem_wdata, mem_dqm_mask,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter funnelling byte/halfword/word requests from NPORTS
// requesters onto a single 32-bit sdram_raw word port with lane masks.
module sdram_port_arb #(
    parameter int unsigned NPORTS  = 2,
    parameter int unsigned ADDR_W  = 25,
    parameter int unsigned TIMEOUT = 0
) (
    input logic             clk,
    input logic             rst,
    sdram_port_arb_if.slave bus
);
    localparam int unsigned GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_grant_q;
    logic            odd_q;
    logic [1:0]      width_q;
    logic [31:0]     tmo_cnt_q;

    logic            found;
    logic [GW-1:0]   pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]     sel_wdata;
    logic [1:0]      sel_width;
    logic            sel_write;
    logic            sel_legal;
    logic [3:0]      sel_mask;
    logic [31:0]     shifted;
    logic [31:0]     rd_masked;
    logic            timed_out;

    // Round-robin pick: first requester after the last granted port.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= int'(NPORTS); i++) begin
            idx = (int'(last_grant_q) + i) % NPORTS;
            if (!found && bus.req_enable[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // Decode the picked request: legality, lane mask, aligned write data.
    always_comb begin
        sel_addr  = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[int'(pick)*32 +: 32];
        sel_width = bus.req_width[int'(pick)*2 +: 2];
        sel_write = bus.req_write[pick];
        sel_legal = (sel_width == 2'b00) || (sel_width == 2'b01) ||
                    (sel_width == 2'b10 && !sel_addr[0]);
        case ({sel_addr[0], sel_width})
            3'b000:  sel_mask = 4'b1110;
            3'b001:  sel_mask = 4'b1100;
            3'b010:  sel_mask = 4'b0000;
            3'b100:  sel_mask = 4'b1101;
            3'b101:  sel_mask = 4'b1001;
            default: sel_mask = 4'b1111;
        endcase
    end

    // Right-justify and zero-extend returned data for the registered access.
    always_comb begin
        shifted = odd_q ? {8'h00, bus.mem_rdata[31:8]} : bus.mem_rdata;
        case (width_q)
            2'b00:   rd_masked = {24'h0, shifted[7:0]};
            2'b01:   rd_masked = {16'h0, shifted[15:0]};
            default: rd_masked = shifted;
        endcase
        timed_out = (TIMEOUT != 0) && (tmo_cnt_q == TIMEOUT - 1);
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            grant_q          <= '0;
            last_grant_q     <= GW'(NPORTS - 1);
            odd_q            <= 1'b0;
            width_q          <= 2'b00;
            tmo_cnt_q        <= '0;
            bus.mem_enable   <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_write    <= 1'b0;
            bus.mem_wdata    <= '0;
            bus.mem_dqm_mask <= 4'b1111;
            bus.req_ready    <= '0;
            bus.req_err      <= '0;
            bus.req_rdata    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_q <= pick;
                        odd_q   <= sel_addr[0];
                        width_q <= sel_width;
                        if (sel_legal) begin
                            bus.mem_enable   <= 1'b1;
                            bus.mem_addr     <= sel_addr[ADDR_W-1:1];
                            bus.mem_write    <= sel_write;
                            bus.mem_wdata    <= sel_addr[0] ? (sel_wdata << 8) : sel_wdata;
                            bus.mem_dqm_mask <= sel_mask;
                            tmo_cnt_q        <= '0;
                            state_q          <= StIssue;
                        end else begin
                            // Illegal access never reaches memory.
                            bus.req_ready <= NPORTS'(1) << pick;
                            bus.req_err   <= NPORTS'(1) << pick;
                            bus.req_rdata <= '0;
                            state_q       <= StDone;
                        end
                    end
                end
                StIssue: begin
                    if (bus.mem_ready) begin
                        bus.mem_enable <= 1'b0;
                        bus.req_ready  <= NPORTS'(1) << grant_q;
                        bus.req_err    <= '0;
                        bus.req_rdata  <= bus.mem_write ? 32'h0 : rd_masked;
                        state_q        <= StDone;
                    end else if (timed_out) begin
                        bus.mem_enable <= 1'b0;
                        bus.req_ready  <= NPORTS'(1) << grant_q;
                        bus.req_err    <= NPORTS'(1) << grant_q;
                        bus.req_rdata  <= '0;
                        state_q        <= StDone;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end
                StDone: begin
                    bus.req_ready <= '0;
                    bus.req_err   <= '0;
                    bus.req_rdata <= '0;
                    last_grant_q  <= grant_q;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: two ports, 25-bit addresses, timeout 8.
module tb_sdram_port_arb;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 25;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sdram_port_arb_if #(.NPORTS(NP), .ADDR_W(AW)) bus ();

    sdram_port_arb #(.NPORTS(NP), .ADDR_W(AW), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_enable = '0;
        bus.req_addr   = '0;
        bus.req_write  = '0;
        bus.req_wdata  = '0;
        bus.req_width  = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] addr, input logic wr,
                            input logic [31:0] wdata, input logic [1:0] width);
        bus.req_addr[p*AW +: AW]  = addr;
        bus.req_write[p]          = wr;
        bus.req_wdata[p*32 +: 32] = wdata;
        bus.req_width[p*2 +: 2]   = width;
        bus.req_enable[p]         = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mem_enable: got %h want 0", bus.mem_enable); end
        n_cmp++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %h want 0", bus.mem_write); end
        n_cmp++; if (bus.mem_addr !== 24'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
        n_cmp++; if (bus.mem_dqm_mask !== 4'b1111) begin n_fail++; $display("FAIL rst_dqm: got %b want 1111", bus.mem_dqm_mask); end
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.req_err !== 2'b00) begin n_fail++; $display("FAIL rst_req_err: got %b want 00", bus.req_err); end
        n_cmp++; if (bus.req_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_req_rdata: got %h want 0", bus.req_rdata); end
        rst = 1'b0;
        step();
    endtask

    // Port 0 byte read at odd address 3.
    task automatic test_read_byte();
        set_port(0, 25'h0000003, 1'b0, 32'h0, 2'b00);
        step();
        n_cmp++; if (bus.mem_enable !== 1'b1) begin n_fail++; $display("FAIL rd_mem_enable: got %h want 1", bus.mem_enable); end
        n_cmp++; if (bus.mem_addr !== 24'h000001) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 000001", bus.mem_addr); end
        n_cmp++; if (bus.mem_dqm_mask !== 4'b1101) begin n_fail++; $display("FAIL rd_dqm: got %b want 1101", bus.mem_dqm_mask); end
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rd_early_ready: got %b want 00", bus.req_ready); end
        bus.mem_rdata = 32'hAABBCCDD;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_req_ready: got %b want 01", bus.req_ready); end
        n_cmp++; if (bus.req_rdata !== 32'h000000CC) begin n_fail++; $display("FAIL rd_req_rdata: got %h want 000000cc", bus.req_rdata); end
        n_cmp++; if (bus.req_err !== 2'b00) begin n_fail++; $display("FAIL rd_req_err: got %b want 00", bus.req_err); end
        n_cmp++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL rd_mem_drop: got %h want 0", bus.mem_enable); end
        bus.req_enable = '0;
        step();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rd_ready_pulse: got %b want 00", bus.req_ready); end
    endtask

    // Port 1 halfword write at odd address; requester lets go after the grant.
    task automatic test_write_half();
        set_port(1, 25'h0000101, 1'b1, 32'h00001234, 2'b01);
        step();
        bus.req_enable = '0;
        n_cmp++; if (bus.mem_enable !== 1'b1) begin n_fail++; $display("FAIL wr_mem_enable: got %h want 1", bus.mem_enable); end
        n_cmp++; if (bus.mem_addr !== 24'h000080) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 000080", bus.mem_addr); end
        n_cmp++; if (bus.mem_dqm_mask !== 4'b1001) begin n_fail++; $display("FAIL wr_dqm: got %b want 1001", bus.mem_dqm_mask); end
        n_cmp++; if (bus.mem_wdata !== 32'h00123400) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want 00123400", bus.mem_wdata); end
        n_cmp++; if (bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL wr_mem_write: got %h want 1", bus.mem_write); end
        step();
        n_cmp++; if (bus.mem_enable !== 1'b1 || bus.mem_addr !== 24'h000080) begin n_fail++; $display("FAIL wr_hold: got en=%h addr=%h want en=1 addr=000080", bus.mem_enable, bus.mem_addr); end
        bus.mem_rdata = 32'hFFFFFFFF;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        n_cmp++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL wr_req_ready: got %b want 10", bus.req_ready); end
        n_cmp++; if (bus.req_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_req_rdata: got %h want 0", bus.req_rdata); end
        n_cmp++; if (bus.req_err !== 2'b00) begin n_fail++; $display("FAIL wr_req_err: got %b want 00", bus.req_err); end
        step();
    endtask

    // Word at odd address and width 11 are rejected without a memory cycle.
    task automatic test_illegal();
        set_port(0, 25'h0000005, 1'b0, 32'h0, 2'b10);
        step();
        bus.req_enable = '0;
        n_cmp++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL ill_mem_enable: got %h want 0", bus.mem_enable); end
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_req_ready: got %b want 01", bus.req_ready); end
        n_cmp++; if (bus.req_err !== 2'b01) begin n_fail++; $display("FAIL ill_req_err: got %b want 01", bus.req_err); end
        n_cmp++; if (bus.req_rdata !== 32'h0) begin n_fail++; $display("FAIL ill_req_rdata: got %h want 0", bus.req_rdata); end
        step();
        n_cmp++; if (bus.req_err !== 2'b00) begin n_fail++; $display("FAIL ill_err_pulse: got %b want 00", bus.req_err); end
        set_port(0, 25'h0000004, 1'b0, 32'h0, 2'b11);
        step();
        bus.req_enable = '0;
        n_cmp++; if (bus.req_err !== 2'b01 || bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL ill_w11: got err=%b en=%h want err=01 en=0", bus.req_err, bus.mem_enable); end
        step();
        // A stray mem_ready while idle must not produce a completion.
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL stray_ready: got %b want 00", bus.req_ready); end
        step();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL stray_ready2: got %b want 00", bus.req_ready); end
    endtask

    // Both ports held from reset; a responsive memory answers each issue at once.
    task automatic test_round_robin();
        int order[$];
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_port(0, 25'h0000000, 1'b0, 32'h0, 2'b10);
        set_port(1, 25'h0000010, 1'b0, 32'h0, 2'b10);
        bus.mem_rdata = 32'h11223344;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            step();
            if (bus.req_ready !== 2'b00) begin
                n_cmp++; if (!$onehot(bus.req_ready)) begin n_fail++; $display("FAIL rr_onehot: got %b want one bit", bus.req_ready); end
                n_cmp++; if (bus.req_rdata !== 32'h11223344) begin n_fail++; $display("FAIL rr_rdata: got %h want 11223344", bus.req_rdata); end
                order.push_back(bus.req_ready[1] ? 1 : 0);
            end
            bus.mem_ready = bus.mem_enable;
        end
        bus.mem_ready  = 1'b0;
        bus.req_enable = '0;
        n_cmp++; if (order.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_cmp++; if (order[i] != i % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
        end
        step();
        step();
    endtask

    // Unanswered request times out after 8 cycles; a reset mid-issue abandons it.
    task automatic test_timeout();
        int cnt;
        logic seen;
        cnt = 0;
        set_port(0, 25'h0000008, 1'b0, 32'h0, 2'b10);
        step();
        for (int c = 0; c < 20; c++) begin
            if (bus.mem_enable !== 1'b1) break;
            cnt++;
            step();
        end
        bus.req_enable = '0;
        n_cmp++; if (cnt != 8) begin n_fail++; $display("FAIL tmo_cycles: got %0d want 8", cnt); end
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL tmo_ready: got %b want 01", bus.req_ready); end
        n_cmp++; if (bus.req_err !== 2'b01) begin n_fail++; $display("FAIL tmo_err: got %b want 01", bus.req_err); end
        step();
        step();
        set_port(0, 25'h0000008, 1'b0, 32'h0, 2'b10);
        step();
        n_cmp++; if (bus.mem_enable !== 1'b1) begin n_fail++; $display("FAIL rst2_issue: got %h want 1", bus.mem_enable); end
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL rst2_mem_enable: got %h want 0", bus.mem_enable); end
        n_cmp++; if (bus.mem_dqm_mask !== 4'b1111) begin n_fail++; $display("FAIL rst2_dqm: got %b want 1111", bus.mem_dqm_mask); end
        bus.req_enable = '0;
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.req_ready !== 2'b00) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst2_no_ready: got %b want 0", seen); end
    endtask

    initial begin
        clear_inputs();
        #2;
        test_reset();
        test_read_byte();
        test_write_half();
        test_illegal();
        test_round_robin();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter NPORTS, default 2: number of requester ports, 1..8.
REQ-002 Parameter ADDR_W, default 25: requester byte-address width; memory word address is ADDR_W-1 bits.
REQ-003 Parameter TIMEOUT, default 0: max cycles awaiting mem_ready; 0 disables timeout.
REQ-004 Reset is asynchronous and active-high; the clock is clk and the reset is rst.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_enable  in  NPORTS  per-port request, level-held until that port's req_ready.
REQ-008 req_addr  in  NPORTS*ADDR_W  per-port byte address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 req_write  in  NPORTS  1 = write, 0 = read.
REQ-010 req_wdata  in  NPORTS*32  right-justified write data.
REQ-011 req_width  in  NPORTS*2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-012 req_rdata  out  32  right-justified, zero-extended read data, valid only with req_ready.
REQ-013 req_ready  out  NPORTS  one-cycle completion pulse per port.
REQ-014 req_err  out  NPORTS  one-cycle error pulse, coincident with req_ready.
REQ-015 mem_enable  out  1  request to sdram_raw, held until mem_ready.
REQ-016 mem_addr  out  ADDR_W-1  word address = granted byte address >> 1.
REQ-017 mem_write  out  1; mem_wdata  out  32; mem_dqm_mask  out  4 (1 = lane masked).
REQ-018 mem_rdata  in  32; mem_ready  in  1  one-cycle completion pulse from sdram_raw.

Function
REQ-019 States IDLE, ISSUE, DONE; reset state IDLE.
REQ-020 IDLE: if any req_enable high, grant the first requesting port in round-robin order beginning at (last_grant+1) mod NPORTS; register its request; move to ISSUE next cycle.
REQ-021 Granted access is legal iff width is 00, or width 01/10 with addr[0]=0, or width 01 with addr[0]=1; width 10 at odd address and width 11 are illegal.
REQ-022 Illegal grant: no memory cycle; go to DONE with err flag set.
REQ-023 ISSUE: mem_enable=1 with registered mem_addr, mem_write, mem_wdata, mem_dqm_mask held stable until the mem_ready cycle inclusive.
REQ-024 dqm mask {odd,width}: 0/00 1110, 0/01 1100, 0/10 0000, 1/00 1101, 1/01 1001.
REQ-025 mem_wdata = req_wdata << 8 when addr[0]=1, else req_wdata unshifted.
REQ-026 On mem_ready in ISSUE: capture (mem_rdata >> 8*addr[0]) masked to 8/16/32 bits per width; drop mem_enable next cycle; go to DONE.
REQ-027 DONE (one cycle): req_ready[grant]=1, req_rdata=captured data (0 for writes/errors), req_err[grant]=err; last_grant<=grant; return to IDLE.
REQ-028 Minimum latency: req_enable rise at cycle 0 -> mem_enable at cycle 1; mem_ready at cycle k -> req_ready at cycle k+1.
REQ-029 TIMEOUT>0: if mem_ready not seen within TIMEOUT cycles of ISSUE entry, drop mem_enable, go to DONE with err=1.
REQ-030 A requester dropping req_enable after grant does not abort; its ready pulse is still issued.
REQ-031 Non-granted ports see req_ready=0, req_err=0; only one req_ready bit high at a time.
REQ-032 A port re-arbitrates only from IDLE; a port holding req_enable through DONE is eligible again in the following IDLE cycle.
REQ-033 mem_ready outside ISSUE is ignored.

Reset
REQ-034 rst high immediately forces IDLE, mem_enable=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_dqm_mask=1111, req_ready=0, req_err=0, req_rdata=0, last_grant=NPORTS-1 (port 0 first priority), timeout counter=0.
REQ-035 Reset mid-ISSUE abandons the transaction; no req_ready is issued for it.

Verification
REQ-036 Port0 read, width 00, addr 0x0000003, mem_rdata 0xAABBCCDD -> mem_addr 0x000001, mask 1101, req_rdata 0x000000CC, req_ready[0] one cycle after mem_ready.
REQ-037 Port1 write, width 01, addr 0x0000101, wdata 0x00001234 -> mem_addr 0x000080, mask 1001, mem_wdata 0x00123400.
REQ-038 Ports 0 and 1 both held requesting from reset -> grants 0,1,0,1; neither starved.
REQ-039 Port0 width 10 at addr 0x0000005 -> no mem_enable; req_ready[0] and req_err[0] pulse together, req_rdata 0.
REQ-040 TIMEOUT=8, mem_ready never asserted -> mem_enable drops after 8 cycles, req_err pulses; rst asserted mid-ISSUE on second run -> mem_enable 0 immediately, no req_ready.
